// File: rtl/ps2_scancode_rx_if.sv
// Key-event and raw-byte bundle produced by the PS/2 scancode receiver.
// The receiver drives it as master; the keyboard mapper or diagnostics read it as slave.
interface ps2_scancode_rx_if;
  logic [10:0] ps2_key;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_err;

  modport master (output ps2_key, output byte_data, output byte_valid, output frame_err);
  modport slave  (input  ps2_key, input  byte_data, input  byte_valid, input  frame_err);
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, deframe 11-bit frames and
// decode E0/F0/E1 prefixes into toggle-strobed {toggle, pressed, ext, code} key events.
module ps2_scancode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 64000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_scancode_rx_if.master  bus
);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int FLT_W = 5;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]       clk_sync_reg, data_sync_reg;
  logic             clk_s, data_s;
  logic [FLT_W-1:0] flt_cnt_reg, flt_cnt_next;
  logic             fclk_reg, fclk_next;
  logic             fall;

  state_t           state_reg, state_next;
  logic [7:0]       shift_reg, shift_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic             parity_reg, parity_next;
  logic [WD_W-1:0]  wd_reg, wd_next;
  logic             frame_done, frame_good, timeout;

  logic [10:0]      key_reg, key_next;
  logic [7:0]       byte_reg, byte_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic             ext_reg, ext_next;
  logic             brk_reg, brk_next;
  logic [2:0]       skip_reg, skip_next;
  logic             is_resp;

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];

  // Filter: a level change is accepted only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    fclk_next    = fclk_reg;
    flt_cnt_next = '0;
    if (clk_s != fclk_reg) begin
      if (flt_cnt_reg == FLT_W'(FILTER_LEN - 1))
        fclk_next = clk_s;
      else
        flt_cnt_next = flt_cnt_reg + FLT_W'(1);
    end
  end

  assign fall = fclk_reg & ~fclk_next;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    wd_next      = wd_reg;
    frame_done   = 1'b0;
    frame_good   = 1'b0;
    timeout      = 1'b0;

    // The edge wins over a coincident timeout because fall is tested first.
    if (state_reg == IDLE || fall)
      wd_next = '0;
    else if (wd_reg == WD_W'(TIMEOUT_CYC))
      timeout = 1'b1;
    else
      wd_next = wd_reg + WD_W'(1);

    case (state_reg)
      IDLE: begin
        if (fall && !data_s) begin
          shift_next   = '0;
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shift_next   = {data_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7)
            state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_next = data_s;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          frame_done = 1'b1;
          frame_good = (^{shift_reg, parity_reg}) & data_s;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (timeout)
      state_next = IDLE;
  end

  always_comb begin
    is_resp = 1'b0;
    case (shift_reg)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_resp = 1'b1;
      default: is_resp = 1'b0;
    endcase
  end

  always_comb begin
    key_next   = key_reg;
    byte_next  = byte_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    ext_next   = ext_reg;
    brk_next   = brk_reg;
    skip_next  = skip_reg;

    if (timeout || (frame_done && !frame_good)) begin
      err_next  = 1'b1;
      ext_next  = 1'b0;
      brk_next  = 1'b0;
      skip_next = '0;
    end else if (frame_done) begin
      valid_next = 1'b1;
      byte_next  = shift_reg;
      // Pause (E1) is followed by seven bytes that must never reach the mapper.
      if (skip_reg != 3'd0)
        skip_next = skip_reg - 3'd1;
      else if (shift_reg == 8'hE1)
        skip_next = 3'd7;
      else if (shift_reg == 8'hE0)
        ext_next = 1'b1;
      else if (shift_reg == 8'hF0)
        brk_next = 1'b1;
      else if (!is_resp) begin
        key_next = {~key_reg[10], ~brk_reg, ext_reg, shift_reg};
        ext_next = 1'b0;
        brk_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      flt_cnt_reg   <= '0;
      fclk_reg      <= 1'b1;
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      parity_reg    <= 1'b0;
      wd_reg        <= '0;
      key_reg       <= '0;
      byte_reg      <= '0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      skip_reg      <= '0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      flt_cnt_reg   <= flt_cnt_next;
      fclk_reg      <= fclk_next;
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      parity_reg    <= parity_next;
      wd_reg        <= wd_next;
      key_reg       <= key_next;
      byte_reg      <= byte_next;
      valid_reg     <= valid_next;
      err_reg       <= err_next;
      ext_reg       <= ext_next;
      brk_reg       <= brk_next;
      skip_reg      <= skip_next;
    end
  end

  assign bus.ps2_key    = key_reg;
  assign bus.byte_data  = byte_reg;
  assign bus.byte_valid = valid_reg;
  assign bus.frame_err  = err_reg;
endmodule
